commit_buffer: RTL and testbench

COMMIT_BUFFER -- requirements
Module: commit_buffer

---
 rtl/commit_buffer_pkg.sv | 18 +
 rtl/commit_fifo.sv | 49 ++++
 rtl/commit_buffer.sv | 163 ++++++++++++++++
 tb/tb_commit_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_buffer_pkg.sv
// Shared constants and helpers for the commit buffer and its storage FIFO.
package commit_buffer_pkg;

  // Opcode of the simulation-trap instruction that ends a run.
  localparam logic [6:0] InstTrap = 7'h6b;

  localparam int unsigned MaxNRet = 4;

  // Pointer width: one extra MSB distinguishes full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic is_trap(input logic [31:0] inst);
    return inst[6:0] == InstTrap;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Circular entry store with one push port and NRet combinational read ports at rd_ptr+i.
module commit_fifo
  import commit_buffer_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  parameter int unsigned NRet  = 2,
  localparam int unsigned PtrW = ptr_w(Depth),
  localparam int unsigned AddrW = PtrW - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic [PtrW-1:0]  pop_cnt_i,
  output logic [Width-1:0] rd_data_o [NRet],
  output logic [PtrW-1:0]  count_o,
  output logic             full_o
);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(push_i);
      rd_ptr_q <= rd_ptr_q + pop_cnt_i;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
    end
  end

  for (genvar i = 0; i < NRet; i++) begin : g_rd
    assign rd_data_o[i] = mem_q[rd_ptr_q[AddrW-1:0] + AddrW'(i)];
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

endmodule

// File: rtl/commit_buffer.sv
// Retire-to-difftest commit queue: buffers retired instructions and presents up to NRET
// per cycle, halting permanently once a trap instruction commits.
module commit_buffer
  import commit_buffer_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 8,
  parameter int unsigned     NRET     = 2,
  parameter logic [XLEN-1:0] PC_START = XLEN'(64'h8000_0000)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  input  logic                 in_wen,
  input  logic [4:0]           in_wdest,
  input  logic [XLEN-1:0]      in_wdata,
  input  logic                 in_skip,
  input  logic [XLEN-1:0]      in_a0,
  input  logic                 cmt_en,
  output logic [NRET-1:0]      cmt_valid,
  output logic [NRET*XLEN-1:0] cmt_pc,
  output logic [NRET*32-1:0]   cmt_inst,
  output logic [NRET-1:0]      cmt_wen,
  output logic [NRET*8-1:0]    cmt_wdest,
  output logic [NRET*XLEN-1:0] cmt_wdata,
  output logic [NRET-1:0]      cmt_skip,
  output logic                 trap_valid,
  output logic [7:0]           trap_code,
  output logic [XLEN-1:0]      trap_pc,
  output logic                 halted,
  output logic                 overflow,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instr_cnt
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  // Entry layout, LSB first: code[8], trap, skip, wdata, wdest[5], wen, inst[32], pc.
  localparam int unsigned EntW  = 2 * XLEN + 48;
  localparam int unsigned OffWd = 10;
  localparam int unsigned OffDs = OffWd + XLEN;
  localparam int unsigned OffWe = OffDs + 5;
  localparam int unsigned OffIn = OffWe + 1;
  localparam int unsigned OffPc = OffIn + 32;

  logic [EntW-1:0] push_data;
  logic [EntW-1:0] rd_data [NRET];
  logic [PtrW-1:0] count, pop_n;
  logic            full, push, trap_hit, stop;
  logic [XLEN-1:0] trap_pc_d;
  logic [7:0]      trap_code_d;

  logic [NRET-1:0]      cmt_valid_q, cmt_wen_q, cmt_skip_q;
  logic [NRET*XLEN-1:0] cmt_pc_q, cmt_wdata_q;
  logic [NRET*32-1:0]   cmt_inst_q;
  logic [NRET*8-1:0]    cmt_wdest_q;
  logic                 trap_valid_q, halted_q, overflow_q;
  logic [7:0]           trap_code_q;
  logic [XLEN-1:0]      trap_pc_q;
  logic [63:0]          cycle_cnt_q, instr_cnt_q;

  assign in_ready  = !reset && !halted_q && !full;
  assign push      = in_valid && in_ready;
  assign push_data = {in_pc, in_inst, in_wen, in_wdest, in_wdata,
                      in_skip || (in_pc == PC_START), is_trap(in_inst), in_a0[7:0]};

  commit_fifo #(
    .Width (EntW),
    .Depth (DEPTH),
    .NRet  (NRET)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_cnt_i   (pop_n),
    .rd_data_o   (rd_data),
    .count_o     (count),
    .full_o      (full)
  );

  // Pop the oldest min(count, NRET) entries, stopping after the first trap.
  always_comb begin
    pop_n       = '0;
    trap_hit    = 1'b0;
    stop        = 1'b0;
    trap_pc_d   = '0;
    trap_code_d = '0;
    if (cmt_en && !halted_q) begin
      for (int i = 0; i < NRET; i++) begin
        if (!stop && (PtrW'(i) < count)) begin
          pop_n = PtrW'(i + 1);
          if (rd_data[i][8]) begin
            stop        = 1'b1;
            trap_hit    = 1'b1;
            trap_pc_d   = rd_data[i][OffPc +: XLEN];
            trap_code_d = rd_data[i][7:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmt_valid_q  <= '0;
      cmt_pc_q     <= '0;
      cmt_inst_q   <= '0;
      cmt_wen_q    <= '0;
      cmt_wdest_q  <= '0;
      cmt_wdata_q  <= '0;
      cmt_skip_q   <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
      halted_q     <= 1'b0;
      overflow_q   <= 1'b0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_q + 64'd1;
      instr_cnt_q  <= instr_cnt_q + 64'(pop_n);
      trap_valid_q <= trap_hit;
      for (int i = 0; i < NRET; i++) begin
        cmt_valid_q[i] <= PtrW'(i) < pop_n;
        if (PtrW'(i) < pop_n) begin
          cmt_pc_q[i*XLEN +: XLEN]    <= rd_data[i][OffPc +: XLEN];
          cmt_inst_q[i*32 +: 32]      <= rd_data[i][OffIn +: 32];
          cmt_wen_q[i]                <= rd_data[i][OffWe];
          cmt_wdest_q[i*8 +: 8]       <= {3'b000, rd_data[i][OffDs +: 5]};
          cmt_wdata_q[i*XLEN +: XLEN] <= rd_data[i][OffWd +: XLEN];
          cmt_skip_q[i]               <= rd_data[i][9];
        end
      end
      if (trap_hit) begin
        trap_pc_q   <= trap_pc_d;
        trap_code_q <= trap_code_d;
        halted_q    <= 1'b1;
      end
      if (in_valid && !in_ready && !halted_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign cmt_valid  = cmt_valid_q;
  assign cmt_pc     = cmt_pc_q;
  assign cmt_inst   = cmt_inst_q;
  assign cmt_wen    = cmt_wen_q;
  assign cmt_wdest  = cmt_wdest_q;
  assign cmt_wdata  = cmt_wdata_q;
  assign cmt_skip   = cmt_skip_q;
  assign trap_valid = trap_valid_q;
  assign trap_code  = trap_code_q;
  assign trap_pc    = trap_pc_q;
  assign halted     = halted_q;
  assign overflow   = overflow_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_commit_buffer.sv
// Directed bench for commit_buffer (XLEN=64, DEPTH=8, NRET=2) with hand-computed expectations.
module tb_commit_buffer;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NRET = 2;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Trap = 32'h0000_006b;

  logic            clock = 1'b0;
  logic            reset, in_valid, in_ready, in_wen, in_skip, cmt_en;
  logic [XLEN-1:0] in_pc, in_wdata, in_a0;
  logic [31:0]     in_inst;
  logic [4:0]      in_wdest;
  logic [NRET-1:0] cmt_valid, cmt_wen, cmt_skip;
  logic [NRET*XLEN-1:0] cmt_pc, cmt_wdata;
  logic [NRET*32-1:0]   cmt_inst;
  logic [NRET*8-1:0]    cmt_wdest;
  logic            trap_valid, halted, overflow;
  logic [7:0]      trap_code;
  logic [XLEN-1:0] trap_pc;
  logic [63:0]     cycle_cnt, instr_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  commit_buffer #(
    .XLEN     (64),
    .DEPTH    (8),
    .NRET     (2),
    .PC_START (64'h8000_0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_wen     (in_wen),
    .in_wdest   (in_wdest),
    .in_wdata   (in_wdata),
    .in_skip    (in_skip),
    .in_a0      (in_a0),
    .cmt_en     (cmt_en),
    .cmt_valid  (cmt_valid),
    .cmt_pc     (cmt_pc),
    .cmt_inst   (cmt_inst),
    .cmt_wen    (cmt_wen),
    .cmt_wdest  (cmt_wdest),
    .cmt_wdata  (cmt_wdata),
    .cmt_skip   (cmt_skip),
    .trap_valid (trap_valid),
    .trap_code  (trap_code),
    .trap_pc    (trap_pc),
    .halted     (halted),
    .overflow   (overflow),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [31:0] inst,
                       input logic [63:0] a0, input logic skip);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    in_a0    = a0;
    in_skip  = skip;
    in_wen   = 1'b0;
    in_wdest = '0;
    in_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; cmt_en = 1'b0;
    drive(64'h0, Nop, 64'h0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmt_en = 1'b0;
    drive(64'h0, Nop, 64'h0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    total++; if ({cmt_valid, trap_valid, halted, overflow} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {cmt_valid, trap_valid, halted, overflow});
    else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", in_ready);
    else passed++;
    total++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0 || trap_pc !== 64'd0)
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", cycle_cnt, instr_cnt);
    else passed++;
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL ready_after_reset got %b exp 1", in_ready);
    else passed++;
    step(); step();
    total++; if (cycle_cnt !== 64'd2) $display("FAIL cycle_cnt got %0d exp 2", cycle_cnt);
    else passed++;
  endtask

  task automatic test_single_issue();
    do_reset();
    cmt_en = 1'b1;
    drive(64'h100, Nop, 64'h0, 1'b0);
    in_wen = 1'b1; in_wdest = 5'h1f; in_wdata = 64'hdead_beef_0000_0001;
    step();
    total++; if (cmt_valid !== 2'b00) $display("FAIL s1_lat got %b exp 00", cmt_valid);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) drive(64'h100 + 64'(4 * i), Nop, 64'h0, 1'b0);
      else in_valid = 1'b0;
      step();
      total++; if (cmt_valid !== 2'b01 || cmt_pc[63:0] !== 64'h100 + 64'(4 * (i - 1)))
        $display("FAIL s1_pop%0d got %b/%h exp 01/%h", i, cmt_valid, cmt_pc[63:0],
                 64'h100 + 64'(4 * (i - 1)));
      else passed++;
      if (i == 1) begin
        total++;
        if (cmt_wen[0] !== 1'b1 || cmt_wdest[7:0] !== 8'h1f ||
            cmt_wdata[63:0] !== 64'hdead_beef_0000_0001 || cmt_inst[31:0] !== Nop)
          $display("FAIL s1_fields got %b/%h/%h exp 1/1f/deadbeef00000001",
                   cmt_wen[0], cmt_wdest[7:0], cmt_wdata[63:0]);
        else passed++;
      end
    end
    step();
    total++; if (cmt_valid !== 2'b00) $display("FAIL s1_idle got %b exp 00", cmt_valid);
    else passed++;
    total++; if (instr_cnt !== 64'd3) $display("FAIL s1_instr got %0d exp 3", instr_cnt);
    else passed++;
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(64'h200 + 64'(4 * i), Nop, 64'h0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0 || overflow !== 1'b0)
      $display("FAIL s2_full got ready=%b ovf=%b exp 0/0", in_ready, overflow);
    else passed++;
    drive(64'h220, Nop, 64'h0, 1'b0);
    step();
    in_valid = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL s2_overflow got %b exp 1", overflow);
    else passed++;
    cmt_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (cmt_valid !== 2'b11 || cmt_pc[63:0] !== 64'h200 + 64'(8 * k) ||
          cmt_pc[127:64] !== 64'h204 + 64'(8 * k))
        $display("FAIL s2_pop%0d got %b/%h/%h exp 11/%h/%h", k, cmt_valid, cmt_pc[63:0],
                 cmt_pc[127:64], 64'h200 + 64'(8 * k), 64'h204 + 64'(8 * k));
      else passed++;
    end
    step();
    total++; if (cmt_valid !== 2'b00 || instr_cnt !== 64'd8)
      $display("FAIL s2_drain got %b/%0d exp 00/8", cmt_valid, instr_cnt);
    else passed++;
  endtask

  task automatic test_skip();
    do_reset();
    cmt_en = 1'b1;
    drive(64'h8000_0000, Nop, 64'h0, 1'b0);
    step();
    drive(64'h8000_0004, Nop, 64'h0, 1'b0);
    step();
    total++; if (cmt_valid[0] !== 1'b1 || cmt_skip[0] !== 1'b1)
      $display("FAIL s3_skip_start got v=%b s=%b exp 1/1", cmt_valid[0], cmt_skip[0]);
    else passed++;
    drive(64'h300, Nop, 64'h0, 1'b1);
    step();
    in_valid = 1'b0;
    total++; if (cmt_pc[63:0] !== 64'h8000_0004 || cmt_skip[0] !== 1'b0)
      $display("FAIL s3_noskip got %h/%b exp 80000004/0", cmt_pc[63:0], cmt_skip[0]);
    else passed++;
    step();
    total++; if (cmt_pc[63:0] !== 64'h300 || cmt_skip[0] !== 1'b1)
      $display("FAIL s3_mmio got %h/%b exp 300/1", cmt_pc[63:0], cmt_skip[0]);
    else passed++;
  endtask

  task automatic test_trap();
    do_reset();
    drive(64'h400, Nop, 64'h0, 1'b0);  step();
    drive(64'h404, Trap, 64'h0, 1'b0); step();
    drive(64'h408, Nop, 64'h0, 1'b0);  step();
    in_valid = 1'b0;
    cmt_en = 1'b1;
    step();
    total++; if (cmt_valid !== 2'b11 || cmt_pc[127:64] !== 64'h404)
      $display("FAIL s4_group got %b/%h exp 11/404", cmt_valid, cmt_pc[127:64]);
    else passed++;
    total++; if (trap_valid !== 1'b1 || trap_code !== 8'h00 || trap_pc !== 64'h404 ||
                 halted !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL s4_trap got v=%b c=%h pc=%h h=%b r=%b exp 1/00/404/1/0",
               trap_valid, trap_code, trap_pc, halted, in_ready);
    else passed++;
    drive(64'h40c, Nop, 64'h0, 1'b0);
    step(); step();
    in_valid = 1'b0;
    total++; if (cmt_valid !== 2'b00 || trap_valid !== 1'b0 || instr_cnt !== 64'd2 ||
                 halted !== 1'b1 || overflow !== 1'b0)
      $display("FAIL s4_halted got v=%b t=%b n=%0d h=%b o=%b exp 00/0/2/1/0",
               cmt_valid, trap_valid, instr_cnt, halted, overflow);
    else passed++;
  endtask

  task automatic test_trap_first();
    do_reset();
    total++; if (halted !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_unhalt got h=%b r=%b exp 0/1", halted, in_ready);
    else passed++;
    drive(64'h500, Trap, 64'h5a, 1'b0); step();
    drive(64'h504, Nop, 64'h0, 1'b0);   step();
    in_valid = 1'b0;
    cmt_en = 1'b1;
    step();
    total++; if (cmt_valid !== 2'b01 || trap_code !== 8'h5a || trap_pc !== 64'h500)
      $display("FAIL trap_slot0 got %b/%h/%h exp 01/5a/500", cmt_valid, trap_code, trap_pc);
    else passed++;
  endtask

  task automatic test_wrap();
    int exp_idx = 0;
    do_reset();
    cmt_en = 1'b1;
    for (int i = 0; i < 20 + 6; i++) begin
      if (i < 20) drive(64'h1000 + 64'(4 * i), Nop, 64'h0, 1'b0);
      else in_valid = 1'b0;
      step();
      for (int s = 0; s < NRET; s++) begin
        if (cmt_valid[s]) begin
          total++;
          if (cmt_pc[s*64 +: 64] !== 64'h1000 + 64'(4 * exp_idx))
            $display("FAIL s5_order%0d got %h exp %h", exp_idx, cmt_pc[s*64 +: 64],
                     64'h1000 + 64'(4 * exp_idx));
          else passed++;
          exp_idx++;
        end
      end
    end
    total++; if (exp_idx != 20 || instr_cnt !== 64'd20)
      $display("FAIL s5_count got %0d/%0d exp 20/20", exp_idx, instr_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(64'h600 + 64'(4 * i), Nop, 64'h0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    total++; if (cmt_valid !== 2'b00 || cycle_cnt !== 64'd0 || halted !== 1'b0 ||
                 in_ready !== 1'b0)
      $display("FAIL s6_reset got v=%b c=%0d h=%b r=%b exp 00/0/0/0",
               cmt_valid, cycle_cnt, halted, in_ready);
    else passed++;
    reset = 1'b0;
    cmt_en = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL s6_ready got %b exp 1", in_ready);
    else passed++;
    step(); step();
    total++; if (cmt_valid !== 2'b00 || instr_cnt !== 64'd0)
      $display("FAIL s6_discard got %b/%0d exp 00/0", cmt_valid, instr_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_full_overflow();
    test_skip();
    test_trap();
    test_trap_first();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
